rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32-entry register file. Shares the single write port (write_enable / write_add / write_data) among NREQ writeback requesters (ALU, load unit, multiplier) with round-robin priority. Registers the winning write onto the port. Optionally tracks per-register pending-write (busy) bits so issue logic can stall on RAW hazards.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  one-hot grant; write i accepted when valid & ready
- req_add  in  NREQ*AW  destination address, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
- wb_hold  in  1  freezes arbitration: no grant, pointer unchanged
- write_enable  out  1  to register file write enable (registered)
- write_add  out  AW  to register file write address (registered)
- write_data  out  DW  to register file write data (registered)
- rsv_valid  in  1  issue reserves a destination register
- rsv_add  in  AW  register being reserved
- rsv_stall  out  1  reservation refused: target already busy
- rs_add, rt_add  in  AW each  operand addresses from issue
- rs_busy, rt_busy  out  1 each  operand has a pending write

## Operation
- Round-robin pointer ptr (0..NREQ-1), reset 0. Search order ptr, ptr+1, … mod NREQ; first valid requester wins.
- req_ready is combinational: exactly one bit high when any req_valid is high, reset is low and wb_hold is low. Otherwise all bits are zero.
- On a grant to requester g: next cycle write_enable=1, write_add=req_add[g], write_data=req_data[g]; ptr <= (g+1) mod NREQ.
- With no grant: write_enable=0; write_add and write_data hold their last values; ptr is unchanged.
- Address 0 is not special-cased; it is written like any other register.
- Requesters must keep valid, add and data stable until ready. The arbiter is never backpressured by the register file; at most one write per cycle.
- Scoreboard: busy[2**AW], reset all 0.
  - Clear: busy[add] <= 0 on the grant cycle.
  - Set: busy[rsv_add] <= 1 when rsv_valid & !rsv_stall.
  - Same register set and cleared in the same cycle: set wins, so the new owner stays busy.
- rsv_stall = rsv_valid & busy[rsv_add] (current-state value, combinational). A refused reservation changes nothing.
- rs_busy = busy[rs_add] and rt_busy = busy[rt_add], combinational from current state.

## Timing
- Grant at posedge N → write_enable high for the cycle after N. The register file captures at the negedge inside that cycle.
- busy clears at the same posedge the write is presented. Issue sees rs_busy=0 in the same cycle the register-file read returns the new value, after the negedge.
- Throughput: one write per cycle sustained. With all NREQ requesters valid, each is granted once every NREQ cycles.
- Reset values: write_enable=0, write_add=0, write_data=0, ptr=0, busy=0, req_ready=0, rsv_stall=0 during reset.
- Reset mid-operation: any in-flight write is dropped (write_enable=0 the next cycle) and all reservations are cleared. Requesters must re-present after reset.
- wb_hold asserted: write_enable goes 0 the next cycle; the scoreboard still accepts reservations.

## Configuration
- RF_WB_SCOREBOARD_EN
  - Defined: busy array and all scoreboard logic compiled in, as specified above.
  - Undefined: no busy storage; rs_busy, rt_busy and rsv_stall are tied 0; rsv_valid and rsv_add are ignored. Arbitration is unchanged.

## Structure
- Shared package rf_pkg holds RF_AW=5, RF_DW=32, RF_DEPTH=32 and the writeback requester index enum (WB_ALU=0, WB_LOAD=1, WB_MUL=2). Defaults take their values from it.
- One sub-module, rr_arbiter (NREQ-wide round-robin: valid in, one-hot grant out, pointer state, enable input). The top level adds the output register and the scoreboard.

## Test plan
- Reset, then req_valid=3'b111 held with adds 1/2/3 → grants in order 0,1,2,0…; write_enable high every cycle; write_add 1,2,3,1 one cycle after each grant.
- Only requester 2 valid (add 7, data 32'hDEADBEEF) → ready[2] the same cycle; next cycle write_enable=1, write_add=7, write_data=DEADBEEF; ptr=0.
- Scoreboard: rsv 5 → rs_add=5 gives rs_busy=1. A second rsv 5 → rsv_stall=1. A grant writing 5 → rs_busy=0 from the next cycle.
- Same cycle: rsv_add=9 and grant to address 9 (busy[9]=0 beforehand, address 9 not previously reserved) → busy[9]=1 afterwards (set wins).
- wb_hold=1 with all requesters valid → req_ready=0, write_enable=0 the next cycle, ptr unchanged; releasing hold resumes from the same ptr.
- Reset asserted while a grant is in flight and busy[4]=1 → next cycle write_enable=0, write_add=0, write_data=0, ptr=0, rs_busy=0 for address 4.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback requester indices.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_MUL  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: NREQ-wide round-robin arbiter. The pointer names the requester
// searched first and advances past each winner.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // NOTE: every combinational output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (enable && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with optional RAW scoreboard.
// Scoreboard compiled in only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_add,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              wb_hold,
  output logic              write_enable,
  output logic [AW-1:0]     write_add,
  output logic [DW-1:0]     write_data,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_add,
  output logic              rsv_stall,
  input  logic [AW-1:0]     rs_add,
  input  logic [AW-1:0]     rt_add,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [AW-1:0]   sel_add;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .enable (!reset && !wb_hold),
    .valid  (req_valid),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  // Grant is one-hot, so an OR-reduction mux selects the winner.
  always_comb begin
    sel_add  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_add  = sel_add  | req_add[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_add    <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= grant_any;
      if (grant_any) begin
        write_add  <= sel_add;
        write_data <= sel_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] busy;

  assign rsv_stall = rsv_valid && !reset && busy[rsv_add];
  assign rs_busy   = busy[rs_add];
  assign rt_busy   = busy[rt_add];

  // NOTE: busy is a flop vector, not RAM, so it is reset; stale reservations after reset would stall issue forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (grant_any) busy[sel_add] <= 1'b0;
      // Set after clear: a same-cycle reservation of the written register keeps it busy for its new owner.
      if (rsv_valid && !rsv_stall) busy[rsv_add] <= 1'b1;
    end
  end
`else
  logic unused_sb;

  assign unused_sb = ^{rsv_valid, rsv_add, rs_add, rt_add};
  assign rsv_stall = 1'b0;
  assign rs_busy   = 1'b0;
  assign rt_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter; scoreboard expectations follow
// whether RF_WB_SCOREBOARD_EN is defined.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  localparam int NROWS = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_add;
  logic [95:0] req_data;
  logic        wb_hold;
  logic        write_enable;
  logic [4:0]  write_add;
  logic [31:0] write_data;
  logic        rsv_valid;
  logic [4:0]  rsv_add;
  logic        rsv_stall;
  logic [4:0]  rs_add;
  logic [4:0]  rt_add;
  logic        rs_busy;
  logic        rt_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_add      (req_add),
    .req_data     (req_data),
    .wb_hold      (wb_hold),
    .write_enable (write_enable),
    .write_add    (write_add),
    .write_data   (write_data),
    .rsv_valid    (rsv_valid),
    .rsv_add      (rsv_add),
    .rsv_stall    (rsv_stall),
    .rs_add       (rs_add),
    .rt_add       (rt_add),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy)
  );

  typedef struct {
    logic             rst;
    logic [2:0]       valid;
    logic [2:0][4:0]  add;
    logic [2:0][31:0] data;
    logic             hold;
    logic             rsv_v;
    logic [4:0]       rsv_a;
    logic [4:0]       rs_a;
    logic [4:0]       rt_a;
    logic [2:0]       e_ready;
    logic             e_we;
    logic [4:0]       e_wadd;
    logic [31:0]      e_wdata;
    logic             e_rs;
    logic             e_rt;
    logic             e_stall;
  } vec_t;

  vec_t vec [NROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic [2:0] valid, input logic hold,
    input logic rsv_v, input logic [4:0] rsv_a, input logic [4:0] rs_a, input logic [4:0] rt_a,
    input logic [2:0] e_ready, input logic e_we, input logic [4:0] e_wadd, input logic [31:0] e_wdata,
    input logic e_rs, input logic e_rt, input logic e_stall);
    vec_t v;
    v.rst = rst; v.valid = valid; v.hold = hold;
    v.add[0] = 5'd1; v.add[1] = 5'd2; v.add[2] = 5'd3;
    v.data[0] = 32'h1000_0001; v.data[1] = 32'h2000_0002; v.data[2] = 32'h3000_0003;
    v.rsv_v = rsv_v; v.rsv_a = rsv_a; v.rs_a = rs_a; v.rt_a = rt_a;
    v.e_ready = e_ready; v.e_we = e_we; v.e_wadd = e_wadd; v.e_wdata = e_wdata;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset     = v.rst;
    req_valid = v.valid;
    req_add   = v.add;
    req_data  = v.data;
    wb_hold   = v.hold;
    rsv_valid = v.rsv_v;
    rsv_add   = v.rsv_a;
    rs_add    = v.rs_a;
    rt_add    = v.rt_a;
  endtask

  initial begin
    vec_t idle;
    int   cnt [3];
    bit   seen;

    // Round robin, hold, single requester, scoreboard, reset mid-flight.
    //                rst valid   hold rsv rsv_a rs  rt   ready   we wadd  wdata          rs rt st
    vec[0]  = mk(1, 3'b111, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0000_0000, 0, 0, 0);
    vec[1]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b001, 0, 0, 32'h0000_0000, 0, 0, 0);
    vec[2]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h1000_0001, 0, 0, 0);
    vec[3]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b100, 1, 2, 32'h2000_0002, 0, 0, 0);
    vec[4]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b001, 1, 3, 32'h3000_0003, 0, 0, 0);
    vec[5]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h1000_0001, 0, 0, 0);
    vec[6]  = mk(0, 3'b111, 1, 0, 0, 0, 0, 3'b000, 1, 2, 32'h2000_0002, 0, 0, 0);
    vec[7]  = mk(0, 3'b111, 1, 0, 0, 0, 0, 3'b000, 0, 2, 32'h2000_0002, 0, 0, 0);
    vec[8]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b100, 0, 2, 32'h2000_0002, 0, 0, 0);
    vec[9]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 3, 32'h3000_0003, 0, 0, 0);
    vec[10] = mk(0, 3'b100, 0, 0, 0, 0, 0, 3'b100, 0, 3, 32'h3000_0003, 0, 0, 0);
    vec[10].add[2] = 5'd7; vec[10].data[2] = 32'hDEAD_BEEF;
    vec[11] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 7, 32'hDEAD_BEEF, 0, 0, 0);
    vec[12] = mk(0, 3'b011, 0, 0, 0, 0, 0, 3'b001, 0, 7, 32'hDEAD_BEEF, 0, 0, 0);
    vec[13] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 1, 32'h1000_0001, 0, 0, 0);
    vec[14] = mk(0, 3'b000, 0, 1, 5, 5, 6, 3'b000, 0, 1, 32'h1000_0001, 0, 0, 0);
    vec[15] = mk(0, 3'b000, 0, 1, 5, 5, 6, 3'b000, 0, 1, 32'h1000_0001, 1, 0, 1);
    vec[16] = mk(0, 3'b010, 0, 0, 0, 5, 6, 3'b010, 0, 1, 32'h1000_0001, 1, 0, 0);
    vec[16].add[1] = 5'd5;
    vec[17] = mk(0, 3'b000, 0, 0, 0, 5, 6, 3'b000, 1, 5, 32'h2000_0002, 0, 0, 0);
    vec[18] = mk(0, 3'b100, 0, 1, 9, 9, 9, 3'b100, 0, 5, 32'h2000_0002, 0, 0, 0);
    vec[18].add[2] = 5'd9;
    vec[19] = mk(0, 3'b000, 0, 0, 0, 9, 9, 3'b000, 1, 9, 32'h3000_0003, 1, 1, 0);
    vec[20] = mk(0, 3'b001, 0, 1, 4, 4, 9, 3'b001, 0, 9, 32'h3000_0003, 0, 1, 0);
    vec[21] = mk(1, 3'b111, 0, 1, 4, 4, 9, 3'b000, 1, 1, 32'h1000_0001, 1, 1, 0);
    vec[22] = mk(0, 3'b000, 0, 0, 0, 4, 9, 3'b000, 0, 0, 32'h0000_0000, 0, 0, 0);
    vec[23] = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b001, 0, 0, 32'h0000_0000, 0, 0, 0);
    vec[24] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 1, 32'h1000_0001, 0, 0, 0);

    idle = mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0);
    drive(idle);
    repeat (2) @(posedge clk);

    for (int r = 0; r < NROWS; r++) begin
      @(negedge clk);
      drive(vec[r]);
      #1;
      check($sformatf("row%0d ready", r), 32'(req_ready), 32'(vec[r].e_ready));
      check($sformatf("row%0d we", r), 32'(write_enable), 32'(vec[r].e_we));
      check($sformatf("row%0d wadd", r), 32'(write_add), 32'(vec[r].e_wadd));
      check($sformatf("row%0d wdata", r), write_data, vec[r].e_wdata);
      check($sformatf("row%0d rs_busy", r), 32'(rs_busy), 32'(SB & vec[r].e_rs));
      check($sformatf("row%0d rt_busy", r), 32'(rt_busy), 32'(SB & vec[r].e_rt));
      check($sformatf("row%0d rsv_stall", r), 32'(rsv_stall), 32'(SB & vec[r].e_stall));
    end

    // Sustained load: pointer is at WB_LOAD, so order is 1,2,0,... one write per cycle.
    idle = mk(0, 3'b111, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0);
    cnt = '{0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(idle);
      #1;
      check($sformatf("rr%0d grant", k), 32'(req_ready), 32'(3'b001 << ((int'(WB_LOAD) + k) % 3)));
      for (int i = 0; i < 3; i++) if (req_ready[i]) cnt[i]++;
      if (k > 0) check($sformatf("rr%0d we", k), 32'(write_enable), 32'd1);
    end
    check("fair alu", cnt[WB_ALU], 32'd3);
    check("fair load", cnt[WB_LOAD], 32'd3);
    check("fair mul", cnt[WB_MUL], 32'd3);

    // Lone multiplier request with bounded wait for the write to appear.
    idle = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0);
    drive(idle);
    @(negedge clk);
    idle.valid = 3'b100;
    idle.add[2] = 5'd17;
    idle.data[2] = 32'hCAFE_0011;
    drive(idle);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(posedge clk);
      #1;
      idle.valid = 3'b000;
      drive(idle);
      if (write_enable && write_add == 5'd17) seen = 1'b1;
    end
    check("mul write seen", 32'(seen), 32'd1);
    check("mul write data", write_data, 32'hCAFE_0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
